// File: rtl/baseband_offchip_pkg.sv
// rtl/baseband_offchip_pkg.sv - shared types and constants for the RX off-chip streamer
package baseband_offchip_pkg;

    typedef enum logic [1:0] {
        MODE_ADC = 2'd0,
        MODE_CNT = 2'd1,
        MODE_FIX = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    localparam logic [7:0] PAT_A5     = 8'hA5;
    localparam logic [7:0] PAT_5A     = 8'h5A;
    localparam int         MAX_DATA_W = 64;

    function automatic int word_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int chunks(input int data_w, input int lanes);
        return (2 * data_w) / lanes;
    endfunction

    // Byte pattern replicated across the widest supported sample; callers keep the low bits.
    function automatic logic [MAX_DATA_W-1:0] rep_byte(input logic [7:0] b);
        logic [MAX_DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_DATA_W / 8; k++) begin
            r[k*8 +: 8] = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/bb_sample_fifo.sv
// rtl/bb_sample_fifo.sv - synchronous sample FIFO with wrap-bit pointers
module bb_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("bb_sample_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // A push while full is legal only alongside a pop; the slot being read is the one overwritten.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d                = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;

endmodule

// File: rtl/baseband_rx_offchip_streamer.sv
// rtl/baseband_rx_offchip_streamer.sv - decimating I/Q capture, FIFO and narrow-lane off-chip serializer
module baseband_rx_offchip_streamer
    import baseband_offchip_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int LANES   = 1,
    parameter int DECIM_W = 8,
    parameter int DROP_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [DECIM_W-1:0]       decim,
    input  logic [DATA_W-1:0]        rx_i_data,
    input  logic [DATA_W-1:0]        rx_q_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [LANES-1:0]         out_bits,
    output logic                     out_sof,
    input  logic                     clear_ovf,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int WORD_W = word_w(DATA_W);
    localparam int CHUNKS = chunks(DATA_W, LANES);
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if ((WORD_W % LANES) != 0) begin : g_bad_lanes
        $error("baseband_rx_offchip_streamer: LANES must divide 2*DATA_W");
    end
    if (DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("baseband_rx_offchip_streamer: DATA_W too wide for the fixed pattern");
    end

    localparam logic [MAX_DATA_W-1:0] FIX_I_FULL = rep_byte(PAT_A5);
    localparam logic [MAX_DATA_W-1:0] FIX_Q_FULL = rep_byte(PAT_5A);
    localparam logic [DATA_W-1:0]     FIX_I      = FIX_I_FULL[DATA_W-1:0];
    localparam logic [DATA_W-1:0]     FIX_Q      = FIX_Q_FULL[DATA_W-1:0];

    logic [DECIM_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic               strobe;
    logic [WORD_W-1:0]  sample;

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
    logic [WORD_W-1:0]  fifo_head;

    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               hs, last_chunk, load;

    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

    // Greater-or-equal compare lets a mid-count reduction of decim wrap on the next cycle.
    always_comb begin
        cnt_d  = cnt_q;
        pc_d   = pc_q;
        strobe = 1'b0;
        if (!en) begin
            cnt_d = '0;
            pc_d  = '0;
        end else if (cnt_q >= decim) begin
            strobe = 1'b1;
            cnt_d  = '0;
            pc_d   = pc_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        case (mode_e'(mode))
            MODE_CNT: sample = {~pc_q, pc_q};
            MODE_FIX: sample = {FIX_Q, FIX_I};
            default:  sample = {rx_q_data, rx_i_data};
        endcase
    end

    assign drop      = strobe && fifo_full && !fifo_pop;
    assign fifo_push = strobe && !drop;

    bb_sample_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (sample),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign hs         = valid_q && out_ready;
    assign last_chunk = (idx_q == IDX_W'(CHUNKS - 1));
    assign load       = (!valid_q || (hs && last_chunk)) && !fifo_empty;
    assign fifo_pop   = load;

    // Reload on the final handshake keeps words back to back; otherwise drop to idle with zeroed bits.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load) begin
            shift_d = fifo_head;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (hs) begin
            if (last_chunk) begin
                shift_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end else begin
                shift_d = shift_q >> LANES;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    // A drop coinciding with a clear counts against the freshly cleared counter.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (!(&drop_cnt_d)) begin
                drop_cnt_d = drop_cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            pc_q       <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_bits   = shift_q[LANES-1:0];
    assign out_sof    = valid_q && (idx_q == '0);
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule
